// File: rtl/datapath_controller.sv
// Instruction register and Moore sequencer for the 16-bit register-file/shifter/ALU datapath.
// Control outputs are registered from the next state, so they follow state and IR only.
module datapath_controller #(
  parameter bit ILLEGAL_TRAP = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s,
  input  logic        load,
  input  logic [15:0] in,
  output logic        w,
  output logic        halted,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        write,
  output logic        asel,
  output logic        bsel,
  output logic        vsel,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic [15:0] datapath_in
);

  typedef enum logic [2:0] {
    ST_WAIT, ST_DECODE, ST_WIMM, ST_GETA, ST_GETB, ST_COMP, ST_WREG, ST_HALT
  } state_t;

  typedef enum logic [2:0] {
    I_MOVI, I_MOVR, I_ADD, I_CMP, I_AND, I_MVN, I_UNDEF
  } instr_t;

  typedef struct packed {
    logic       w;
    logic       halted;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       write;
    logic       asel;
    logic       vsel;
    logic [1:0] shift;
    logic [1:0] aluop;
    logic [2:0] readnum;
    logic [2:0] writenum;
  } ctrl_t;

  state_t      state;
  state_t      state_nx;
  logic [15:0] ir;
  logic [15:0] ir_nx;
  ctrl_t       ctrl;

  function automatic instr_t classify(input logic [15:0] word);
    instr_t k;
    case ({word[15:13], word[12:11]})
      5'b110_10: k = I_MOVI;
      5'b110_00: k = I_MOVR;
      5'b101_00: k = I_ADD;
      5'b101_01: k = I_CMP;
      5'b101_10: k = I_AND;
      5'b101_11: k = I_MVN;
      default:   k = I_UNDEF;
    endcase
    return k;
  endfunction

  function automatic ctrl_t decode(input state_t st, input logic [15:0] word);
    ctrl_t  c;
    instr_t k;
    c          = '0;
    k          = classify(word);
    c.readnum  = word[2:0];
    c.writenum = word[7:5];
    case (st)
      ST_WAIT: c.w = 1'b1;
      ST_WIMM: begin
        c.write    = 1'b1;
        c.vsel     = 1'b1;
        c.writenum = word[10:8];
      end
      ST_GETA: begin
        c.readnum = word[10:8];
        c.loada   = 1'b1;
      end
      ST_GETB: c.loadb = 1'b1;
      ST_COMP: begin
        c.shift = word[4:3];
        c.aluop = (word[15:13] == 3'b101) ? word[12:11] : 2'b00;
        c.asel  = (k == I_MOVR);
        if (k == I_CMP) c.loads = 1'b1;
        else            c.loadc = 1'b1;
      end
      ST_WREG: c.write = 1'b1;
      ST_HALT: c.halted = 1'b1;
      default: c.w = 1'b0;
    endcase
    return c;
  endfunction

  // Next state and IR capture; IR only accepts a new word while idle.
  always_comb begin
    state_nx = state;
    ir_nx    = ir;
    case (state)
      ST_WAIT: begin
        if (load) ir_nx = in;
        else      ir_nx = ir;
        if (s) state_nx = ST_DECODE;
        else   state_nx = ST_WAIT;
      end
      ST_DECODE: begin
        case (classify(ir))
          I_MOVI:               state_nx = ST_WIMM;
          I_MOVR, I_MVN:        state_nx = ST_GETB;
          I_ADD, I_CMP, I_AND:  state_nx = ST_GETA;
          default:              state_nx = ILLEGAL_TRAP ? ST_HALT : ST_WAIT;
        endcase
      end
      ST_WIMM: state_nx = ST_WAIT;
      ST_GETA: state_nx = ST_GETB;
      ST_GETB: state_nx = ST_COMP;
      ST_COMP: begin
        if (classify(ir) == I_CMP) state_nx = ST_WAIT;
        else                       state_nx = ST_WREG;
      end
      ST_WREG: state_nx = ST_WAIT;
      ST_HALT: state_nx = ST_HALT;
      default: state_nx = ST_WAIT;
    endcase
  end

  // State, IR and registered control word.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_WAIT;
      ir    <= 16'h0000;
      ctrl  <= decode(ST_WAIT, 16'h0000);
    end else begin
      state <= state_nx;
      ir    <= ir_nx;
      ctrl  <= decode(state_nx, ir_nx);
    end
  end

  // Enables are masked during reset so nothing commits on the reset edge.
  assign w           = ctrl.w | reset;
  assign halted      = ctrl.halted & ~reset;
  assign loada       = ctrl.loada & ~reset;
  assign loadb       = ctrl.loadb & ~reset;
  assign loadc       = ctrl.loadc & ~reset;
  assign loads       = ctrl.loads & ~reset;
  assign write       = ctrl.write & ~reset;
  assign asel        = ctrl.asel;
  assign bsel        = 1'b0;
  assign vsel        = ctrl.vsel;
  assign shift       = ctrl.shift;
  assign ALUop       = ctrl.aluop;
  assign readnum     = ctrl.readnum;
  assign writenum    = ctrl.writenum;
  assign datapath_in = {{8{ir[7]}}, ir[7:0]};

endmodule

// File: tb/tb_datapath_controller.sv
// Bench for datapath_controller: a per-instruction micro-step plan model checked every cycle,
// plus hand-computed latency/register/immediate expectations. Two instances cover both trap modes.
module tb_datapath_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        s = 1'b0;
  logic        load = 1'b0;
  logic [15:0] in = 16'h0000;

  logic a_w, a_halted, a_loada, a_loadb, a_loadc, a_loads, a_write, a_asel, a_bsel, a_vsel;
  logic [1:0] a_shift, a_aluop;
  logic [2:0] a_readnum, a_writenum;
  logic [15:0] a_dp;
  logic t_w, t_halted, t_loada, t_loadb, t_loadc, t_loads, t_write, t_asel, t_bsel, t_vsel;
  logic [1:0] t_shift, t_aluop;
  logic [2:0] t_readnum, t_writenum;
  logic [15:0] t_dp;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  datapath_controller #(.ILLEGAL_TRAP(1'b0)) dut (
    .clk(clk), .reset(reset), .s(s), .load(load), .in(in),
    .w(a_w), .halted(a_halted), .loada(a_loada), .loadb(a_loadb), .loadc(a_loadc),
    .loads(a_loads), .write(a_write), .asel(a_asel), .bsel(a_bsel), .vsel(a_vsel),
    .shift(a_shift), .ALUop(a_aluop), .readnum(a_readnum), .writenum(a_writenum),
    .datapath_in(a_dp)
  );

  datapath_controller #(.ILLEGAL_TRAP(1'b1)) dut_trap (
    .clk(clk), .reset(reset), .s(s), .load(load), .in(in),
    .w(t_w), .halted(t_halted), .loada(t_loada), .loadb(t_loadb), .loadc(t_loadc),
    .loads(t_loads), .write(t_write), .asel(t_asel), .bsel(t_bsel), .vsel(t_vsel),
    .shift(t_shift), .ALUop(t_aluop), .readnum(t_readnum), .writenum(t_writenum),
    .datapath_in(t_dp)
  );

  typedef struct packed {
    logic w, halted, loada, loadb, loadc, loads, write, asel, bsel, vsel;
    logic [1:0] shift, aluop;
    logic [2:0] rn, wn;
    logic [15:0] dp;
  } ov_t;

  typedef enum {M_NONE, M_WIMM, M_READA, M_READB, M_ALU, M_WB, M_IDLE, M_HALT} mstep_t;

  ov_t act_a, act_t;
  assign act_a = {a_w, a_halted, a_loada, a_loadb, a_loadc, a_loads, a_write, a_asel, a_bsel,
                  a_vsel, a_shift, a_aluop, a_readnum, a_writenum, a_dp};
  assign act_t = {t_w, t_halted, t_loada, t_loadb, t_loadc, t_loads, t_write, t_asel, t_bsel,
                  t_vsel, t_shift, t_aluop, t_readnum, t_writenum, t_dp};

  mstep_t      plan_q[$];
  logic [15:0] m_ir = 16'h0000;
  logic [15:0] trap_ir = 16'h0000;
  bit          trap_pend = 1'b0;
  bit          trap_halt = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // What the controller must present during one micro-step of an instruction.
  function automatic ov_t expect_vec(input logic [15:0] ir, input mstep_t k);
    ov_t e;
    bit  is_cmp;
    e      = '0;
    is_cmp = (ir[15:11] == 5'b10101);
    e.rn   = ir[2:0];
    e.wn   = ir[7:5];
    e.dp   = {{8{ir[7]}}, ir[7:0]};
    case (k)
      M_IDLE:  e.w = 1'b1;
      M_HALT:  e.halted = 1'b1;
      M_WIMM:  begin e.write = 1'b1; e.vsel = 1'b1; e.wn = ir[10:8]; end
      M_READA: begin e.rn = ir[10:8]; e.loada = 1'b1; end
      M_READB: e.loadb = 1'b1;
      M_ALU: begin
        e.shift = ir[4:3];
        e.aluop = (ir[15:13] == 3'b101) ? ir[12:11] : 2'b00;
        e.asel  = (ir[15:13] == 3'b110);
        e.loads = is_cmp;
        e.loadc = !is_cmp;
      end
      M_WB:    e.write = 1'b1;
      default: e.w = 1'b0;
    endcase
    return e;
  endfunction

  task automatic build_plan(input logic [15:0] ir);
    case (ir[15:11])
      5'b11010:          plan_q = '{M_NONE, M_WIMM};
      5'b11000, 5'b10111: plan_q = '{M_NONE, M_READB, M_ALU, M_WB};
      5'b10100, 5'b10110: plan_q = '{M_NONE, M_READA, M_READB, M_ALU, M_WB};
      5'b10101:          plan_q = '{M_NONE, M_READA, M_READB, M_ALU};
      default: begin
        plan_q    = '{M_NONE};
        trap_pend = 1'b1;
      end
    endcase
  endtask

  // Compare on the falling edge, then advance the model with the inputs the next rising edge sees.
  initial begin
    ov_t ea;
    forever begin
      @(negedge clk);
      if (reset) begin
        check("reset_gate_main", {a_w, a_halted, a_loada, a_loadb, a_loadc, a_loads, a_write},
              {1'b1, 6'b000000});
        check("reset_gate_trap", {t_w, t_halted, t_loada, t_loadb, t_loadc, t_loads, t_write},
              {1'b1, 6'b000000});
      end else begin
        ea = (plan_q.size() > 0) ? expect_vec(m_ir, plan_q[0]) : expect_vec(m_ir, M_IDLE);
        check("cycle_main", act_a, ea);
        check("cycle_trap", act_t, trap_halt ? expect_vec(trap_ir, M_HALT) : ea);
      end
      if (reset) begin
        plan_q.delete();
        m_ir      = 16'h0000;
        trap_pend = 1'b0;
        trap_halt = 1'b0;
      end else if (plan_q.size() > 0) begin
        void'(plan_q.pop_front());
        if (plan_q.size() == 0 && trap_pend) begin
          trap_pend = 1'b0;
          if (!trap_halt) trap_ir = m_ir;
          trap_halt = 1'b1;
        end
      end else begin
        if (load) m_ir = in;
        if (s) build_plan(m_ir);
      end
    end
  end

  task automatic issue(input logic [15:0] instr, input bit same, input int exp_low,
                       input int exp_wn, input int exp_dp, input int exp_lds);
    int cnt, nwr, nlds;
    logic [2:0]  wn;
    logic [15:0] dp;
    cnt = 0; nwr = 0; nlds = 0; wn = 3'd0; dp = 16'h0000;
    in   = instr;
    load = 1'b1;
    s    = same;
    @(posedge clk); #1;
    if (!same) begin
      load = 1'b0;
      s    = 1'b1;
      @(posedge clk); #1;
    end
    load = 1'b0;
    s    = 1'b0;
    while (a_w !== 1'b1 && cnt < 20) begin
      cnt++;
      if (a_write) begin nwr++; wn = a_writenum; dp = a_dp; end
      if (a_loads) nlds++;
      @(posedge clk); #1;
    end
    check("latency", cnt, exp_low);
    check("write_count", nwr, (exp_wn >= 0) ? 1 : 0);
    if (exp_wn >= 0) check("writenum", wn, exp_wn[2:0]);
    if (exp_dp >= 0) check("imm_value", dp, exp_dp[15:0]);
    check("status_loads", nlds, exp_lds);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    check("rst_w", a_w, 1'b1);
    check("rst_enables", {a_loada, a_loadb, a_loadc, a_loads, a_write}, 5'b00000);
    check("rst_fields", {a_shift, a_aluop, a_readnum, a_writenum, a_dp}, 26'd0);

    issue(16'hD205, 1'b1, 2, 2, 16'h0005, 0);
    issue(16'hD2FB, 1'b0, 2, 2, 16'hFFFB, 0);
    issue(16'hA162, 1'b0, 5, 3, -1, 0);
    issue(16'hA90A, 1'b1, 4, -1, -1, 1);
    issue(16'hC0A1, 1'b0, 4, 5, -1, 0);
    issue(16'hB8E1, 1'b0, 4, 7, -1, 0);

    // Busy-time s/load must be ignored, then reset lands in WREG.
    in = 16'hA162; load = 1'b1; s = 1'b1;
    @(posedge clk); #1;
    in = 16'hD2FF; load = 1'b1; s = 1'b1;
    @(posedge clk); #1;
    load = 1'b0; s = 1'b0;
    for (int i = 0; i < 10 && !a_write; i++) begin
      @(posedge clk); #1;
    end
    check("wreg_reached", a_write, 1'b1);
    check("busy_ir_kept", {a_writenum, a_dp}, {3'd3, 16'h0062});
    reset = 1'b1;
    #1 check("reset_masks_write", a_write, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    check("post_rst_idle", {a_w, a_readnum, a_writenum, a_dp}, {1'b1, 22'd0});

    issue(16'hE000, 1'b0, 1, -1, -1, 0);
    check("undef_main_nohalt", a_halted, 1'b0);
    check("trap_halted", {t_halted, t_w}, 2'b10);
    for (int p = 0; p < 3; p++) begin
      s = 1'b1;
      @(posedge clk); #1;
      s = 1'b0;
      repeat (2) @(posedge clk);
      #1;
    end
    check("trap_sticky", {t_halted, t_w}, 2'b10);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("trap_cleared", {t_halted, t_w}, 2'b01);
    issue(16'hD205, 1'b0, 2, 2, 16'h0005, 0);
    repeat (3) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
